// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: debounces raw set/clear requests, edge-detects them and issues
// clean, fixed-width, mutually exclusive s/r pulses to a downstream sr_ff.
// A shadow copy of the flip-flop state is kept for monitoring.
// Optional feature macro: SR_DRIVE_TOGGLE_EN adds a debounced toggle request (tog_in).
module sr_drive_ctrl #(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
`ifdef SR_DRIVE_TOGGLE_EN
    input  logic tog_in,
`endif
    output logic s,
    output logic r,
    output logic busy,
    output logic q_shadow,
    output logic conflict
);

    // Lane 0 = set, lane 1 = clear, lane 2 = toggle (when enabled).
`ifdef SR_DRIVE_TOGGLE_EN
    localparam int unsigned NIN = 3;
`else
    localparam int unsigned NIN = 2;
`endif
    localparam int unsigned DW   = $clog2(DEB_CYC + 1);
    localparam int unsigned CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        S_PULSE = 2'd1,
        R_PULSE = 2'd2,
        GAP     = 2'd3
    } state_t;

    logic [NIN-1:0]         raw;
    logic [NIN-1:0]         stable_q, stable_d;
    logic [NIN-1:0]         stable_dly_q, stable_dly_d;
    logic [NIN-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [NIN-1:0]         rise;

    logic                   set_ev, clr_ev;
    logic                   set_take, clr_take;
    logic                   set_pend_q, set_pend_d;
    logic                   clr_pend_q, clr_pend_d;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   q_shadow_q, q_shadow_d;
    logic                   conflict_q, conflict_d;
    logic                   s_q, s_d;
    logic                   r_q, r_d;
    logic                   busy_q, busy_d;

    // Gather raw request lines into one vector for the debounce lanes.
    always_comb begin
        raw    = '0;
        raw[0] = set_in;
        raw[1] = clr_in;
`ifdef SR_DRIVE_TOGGLE_EN
        raw[2] = tog_in;
`endif
    end

    // Debounce: accept a new level only after DEB_CYC consecutive differing samples.
    always_comb begin
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        deb_cnt_d    = '0;
        for (int i = 0; i < int'(NIN); i++) begin
            if (raw[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYC - 1)) begin
                    stable_d[i] = raw[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level, seen one edge after stable rises.
    assign rise = stable_q & ~stable_dly_q;

    // Map debounced edges to set/clear requests; a toggle loses to a direct request.
    always_comb begin
        set_ev = rise[0];
        clr_ev = rise[1];
`ifdef SR_DRIVE_TOGGLE_EN
        if (rise[2] && !rise[0] && !rise[1]) begin
            set_ev = ~q_shadow_q;
            clr_ev = q_shadow_q;
        end
`endif
    end

    // Pulse sequencer: next state, counters, pend bookkeeping and registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        set_take   = 1'b0;
        clr_take   = 1'b0;
        conflict_d = 1'b0;
        q_shadow_d = q_shadow_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (set_pend_q && clr_pend_q) begin
                    set_take   = 1'b1;
                    clr_take   = 1'b1;
                    conflict_d = 1'b1;
                end else if (set_pend_q) begin
                    set_take = 1'b1;
                    state_d  = S_PULSE;
                end else if (clr_pend_q) begin
                    clr_take = 1'b1;
                    state_d  = R_PULSE;
                end
            end
            S_PULSE, R_PULSE: begin
                if (cnt_q == CW'(PULSE_CYC - 1)) begin
                    q_shadow_d = (state_q == S_PULSE);
                    cnt_d      = '0;
                    state_d    = (GAP_CYC == 0) ? IDLE : GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A new edge on the same cycle as a take re-arms the one-deep pend.
        set_pend_d = set_ev | (set_pend_q & ~set_take);
        clr_pend_d = clr_ev | (clr_pend_q & ~clr_take);

        s_d    = (state_d == S_PULSE);
        r_d    = (state_d == R_PULSE);
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            deb_cnt_q    <= '0;
            set_pend_q   <= 1'b0;
            clr_pend_q   <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            q_shadow_q   <= 1'b0;
            conflict_q   <= 1'b0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            deb_cnt_q    <= deb_cnt_d;
            set_pend_q   <= set_pend_d;
            clr_pend_q   <= clr_pend_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            q_shadow_q   <= q_shadow_d;
            conflict_q   <= conflict_d;
            s_q          <= s_d;
            r_q          <= r_d;
            busy_q       <= busy_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign q_shadow = q_shadow_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl: each step drives inputs, queues the outputs
// expected after the next rising edge, then pops and checks them.
module tb_sr_drive_ctrl;

    localparam int DEB   = 4;
    localparam int PULSE = 2;
    localparam int GAP   = 1;

    logic clk;
    logic rst;
    logic set_in;
    logic clr_in;
`ifdef SR_DRIVE_TOGGLE_EN
    logic tog_in;
`endif
    logic s;
    logic r;
    logic busy;
    logic q_shadow;
    logic conflict;

    typedef struct {
        logic [4:0] v;   // {s, r, busy, q_shadow, conflict}
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    sr_drive_ctrl #(
        .DEB_CYC   (DEB),
        .PULSE_CYC (PULSE),
        .GAP_CYC   (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_in   (set_in),
        .clr_in   (clr_in),
`ifdef SR_DRIVE_TOGGLE_EN
        .tog_in   (tog_in),
`endif
        .s        (s),
        .r        (r),
        .busy     (busy),
        .q_shadow (q_shadow),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string name, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%b expected=%b at %0t", tag, name, obs, expv, $time);
        end
    endtask

    // Pop the oldest expectation and compare against the DUT outputs.
    task automatic check_out();
        exp_t e;
        chk("global", "s_and_r_exclusive", s & r, 1'b0);
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, "s",        s,        e.v[4]);
            chk(e.tag, "r",        r,        e.v[3]);
            chk(e.tag, "busy",     busy,     e.v[2]);
            chk(e.tag, "q_shadow", q_shadow, e.v[1]);
            chk(e.tag, "conflict", conflict, e.v[0]);
        end
    endtask

    task automatic step(input logic rv, input logic sv, input logic cv, input logic tv,
                        input logic [4:0] ev, input string tag);
        rst    = rv;
        set_in = sv;
        clr_in = cv;
`ifdef SR_DRIVE_TOGGLE_EN
        tog_in = tv;
`else
        if (tv) $display("note: toggle stimulus ignored in this build");
`endif
        exp_q.push_back('{v: ev, tag: tag});
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Expected outputs i edges after a single request line rose (E1 = first sampling edge).
    function automatic logic [4:0] cmd_exp(input int i, input logic is_set, input logic q0);
        logic p, b, q;
        p = (i >= DEB + 2) && (i <= DEB + PULSE + 1);
        b = (i >= DEB + 2) && (i <= DEB + PULSE + GAP + 1);
        q = (i >= DEB + PULSE + 2) ? is_set : q0;
        return {p & is_set, p & ~is_set, b, q, 1'b0};
    endfunction

    function automatic logic [4:0] idle_exp(input logic q0);
        return {3'b000, q0, 1'b0};
    endfunction

    initial begin
        logic [4:0] ev;
        logic       bounce_pat [7];

        rst = 1'b1;
        set_in = 1'b0;
        clr_in = 1'b0;
`ifdef SR_DRIVE_TOGGLE_EN
        tog_in = 1'b0;
`endif
        bounce_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset held with set_in high: everything stays low.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, idle_exp(1'b0), "reset");

        // Release reset with set_in still high: s first appears after E6.
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0, cmd_exp(i, 1'b1, 1'b0), "clean_set");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, idle_exp(1'b1), "set_release");

        // Bouncing clear never reaches DEB consecutive samples.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, bounce_pat[i], 1'b0, idle_exp(1'b1), "bounce");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, idle_exp(1'b1), "bounce_tail");

        // Clean clear drops the shadow state.
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0, cmd_exp(i, 1'b0, 1'b1), "clean_clr");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, idle_exp(1'b0), "clr_release");

        // Simultaneous set and clear: one conflict cycle, no pulse.
        for (int i = 1; i <= 10; i++) begin
            ev = {4'b0000, (i == DEB + 2) ? 1'b1 : 1'b0};
            step(1'b0, 1'b1, 1'b1, 1'b0, ev, "simultaneous");
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, idle_exp(1'b0), "simul_release");

        // Back-to-back: clear edge lands during the s pulse and is served after one IDLE cycle.
        for (int i = 1; i <= 16; i++) begin
            ev[4] = (i == 6) || (i == 7);
            ev[3] = (i == 10) || (i == 11);
            ev[2] = ((i >= 6) && (i <= 8)) || ((i >= 10) && (i <= 12));
            ev[1] = (i >= 8) && (i <= 11);
            ev[0] = 1'b0;
            step(1'b0, 1'b1, (i >= 3), 1'b0, ev, "back_to_back");
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, idle_exp(1'b0), "b2b_release");

        // Reset mid-pulse: s drops on the reset edge and the pending clear is lost.
        for (int i = 1; i <= 7; i++) begin
            ev = {(i >= 6) ? 1'b1 : 1'b0, 1'b0, (i >= 6) ? 1'b1 : 1'b0, 2'b00};
            step(1'b0, 1'b1, (i >= 3), 1'b0, ev, "pre_reset_pulse");
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, idle_exp(1'b0), "reset_mid_pulse");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0, idle_exp(1'b0), "after_reset");

`ifdef SR_DRIVE_TOGGLE_EN
        // Two toggle presses: first sets, second clears.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, idle_exp(1'b0), "tog_reset");
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, cmd_exp(i, 1'b1, 1'b0), "tog_first");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, idle_exp(1'b1), "tog_release1");
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, cmd_exp(i, 1'b0, 1'b1), "tog_second");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, idle_exp(1'b0), "tog_release2");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
